serial_frame_tx: RTL and testbench

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

---
 rtl/serial_frame_pkg.sv | 14 +
 rtl/piso_shreg.sv | 35 +++
 rtl/serial_frame_tx.sv | 123 ++++++++++++
 tb/tb_serial_frame_tx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and defaults for the serial frame transmitter.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPre  = 2'd1,
    StData = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [3:0]  PREAMBLE_DEFAULT = 4'b1101;
  localparam int unsigned NBITS_DEFAULT    = 8;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in serial-out shift register, MSB first.
// Shifting rotates the MSB back into bit 0 so a full pass restores the payload.
module piso_shreg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [Width-1:0] data_i,
  output logic             msb_o
);

  logic [Width-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (shift_i) begin
      data_d = (data_q << 1) | (data_q >> (Width - 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb_o = data_q[Width-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: 4-bit preamble then NBITS payload bits, MSB first,
// followed by a one-cycle DONE; optional back-to-back retransmission.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int unsigned NBITS    = NBITS_DEFAULT,
  parameter logic [3:0]  PREAMBLE = PREAMBLE_DEFAULT
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             start,
  input  logic [NBITS-1:0] data_in,
  input  logic             repeat_en,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_o
);

  localparam int unsigned MaxCnt = ((NBITS > 4) ? NBITS : 4) - 1;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] PreLoad  = CntW'(3);
  localparam logic [CntW-1:0] DataLoad = CntW'(NBITS - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            serial_out_q, serial_out_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            load, shift, msb;
  logic [1:0]      pre_idx;

  piso_shreg #(
    .Width (NBITS)
  ) u_shreg (
    .clk_i   (clk_2),
    .rst_i   (reset),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (data_in),
    .msb_o   (msb)
  );

  assign pre_idx = 2'(cnt_q - CntW'(1));

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    serial_out_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StPre;
          cnt_d        = PreLoad;
          serial_out_d = PREAMBLE[3];
          busy_d       = 1'b1;
          load         = 1'b1;
        end
      end
      StPre: begin
        busy_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d        = cnt_q - CntW'(1);
          serial_out_d = PREAMBLE[pre_idx];
        end else begin
          state_d      = StData;
          cnt_d        = DataLoad;
          serial_out_d = msb;
          shift        = 1'b1;
        end
      end
      StData: begin
        if (cnt_q != '0) begin
          cnt_d        = cnt_q - CntW'(1);
          serial_out_d = msb;
          shift        = 1'b1;
          busy_d       = 1'b1;
        end else begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        if (repeat_en) begin
          state_d      = StPre;
          cnt_d        = PreLoad;
          serial_out_d = PREAMBLE[3];
          busy_d       = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      serial_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      serial_out_q <= serial_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign serial_out = serial_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Randomised and directed bench for serial_frame_tx with a queue-based frame model.
module tb_serial_frame_tx;

  localparam int unsigned NB  = 8;
  localparam logic [3:0]  PRE = 4'b1101;

  typedef struct packed {
    logic       so;
    logic       busy;
    logic       done;
    logic [1:0] st;
  } rec_t;

  localparam rec_t IdleRec = '{so: 1'b0, busy: 1'b0, done: 1'b0, st: 2'd0};

  logic          clk_2 = 1'b0;
  logic          reset;
  logic          start;
  logic [NB-1:0] data_in;
  logic          repeat_en;
  logic          serial_out, busy, done;
  logic [1:0]    state_o;

  int   checks   = 0;
  int   failures = 0;
  rec_t exp_q[$];
  bit   armed    = 1'b0;
  logic [1:0]    last_st = 2'd0;
  logic [NB-1:0] payload_m = '0;

  serial_frame_tx #(
    .NBITS    (NB),
    .PREAMBLE (PRE)
  ) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .repeat_en  (repeat_en),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done),
    .state_o    (state_o)
  );

  always #5 clk_2 = ~clk_2;

  // One frame as seen on the outputs: preamble, payload, one DONE cycle.
  function automatic void push_frame(input logic [NB-1:0] d);
    rec_t r;
    for (int i = 3; i >= 0; i--) begin
      r = '{so: PRE[i], busy: 1'b1, done: 1'b0, st: 2'd1};
      exp_q.push_back(r);
    end
    for (int i = NB - 1; i >= 0; i--) begin
      r = '{so: d[i], busy: 1'b1, done: 1'b0, st: 2'd2};
      exp_q.push_back(r);
    end
    r = '{so: 1'b0, busy: 1'b0, done: 1'b1, st: 2'd3};
    exp_q.push_back(r);
  endfunction

  // Reference model: decides at each edge what the coming cycles must show.
  always @(posedge clk_2) begin
    if (reset) begin
      exp_q.delete();
      exp_q.push_back(IdleRec);
      armed = 1'b1;
    end else if (armed && exp_q.size() == 0) begin
      if (last_st == 2'd3 && repeat_en) begin
        push_frame(payload_m);
      end else if (last_st == 2'd0 && start) begin
        payload_m = data_in;
        push_frame(payload_m);
      end else begin
        exp_q.push_back(IdleRec);
      end
    end
  end

  // Monitor: one expected record per cycle, sampled on the falling edge.
  always @(negedge clk_2) begin
    rec_t e;
    rec_t a;
    if (armed) begin
      a = '{so: serial_out, busy: busy, done: done, st: state_o};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL underflow: no expected record, actual=%b", a);
      end else begin
        e = exp_q.pop_front();
        last_st = e.st;
        if (a !== e) begin
          failures++;
          $display("FAIL cycle_outputs t=%0t actual so/busy/done/st=%b/%b/%b/%0d required=%b/%b/%b/%0d",
                   $time, a.so, a.busy, a.done, a.st, e.so, e.busy, e.done, e.st);
        end
      end
      checks++;
      if (done === 1'b1 && busy === 1'b1) begin
        failures++;
        $display("FAIL done_busy_overlap t=%0t actual done=%b busy=%b required not both 1",
                 $time, done, busy);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; data_in = '0; repeat_en = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Single frame, 8'hA5.
    data_in = 8'hA5; start = 1'b1;
    tick(1);
    start = 1'b0; data_in = 8'h00;
    tick(16);

    // start held high: no queuing, one idle cycle between frames.
    data_in = 8'h3C; start = 1'b1;
    tick(20);
    start = 1'b0;
    tick(16);

    // Repeat with payload changed mid-frame.
    data_in = 8'hF0; repeat_en = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    data_in = 8'h0F;
    tick(26);
    repeat_en = 1'b0;
    tick(16);

    // Reset during the third payload bit, then immediate restart.
    data_in = 8'h96; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    reset = 1'b1;
    tick(1);
    reset = 1'b0; start = 1'b1; data_in = 8'h5A;
    tick(1);
    start = 1'b0;
    tick(16);

    // All-zero then all-one payloads.
    data_in = 8'h00; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(14);
    data_in = 8'hFF; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(16);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      start     = ($urandom_range(3) == 0);
      repeat_en = ($urandom_range(7) == 0);
      reset     = ($urandom_range(63) == 0);
      data_in   = NB'($urandom);
      tick(1);
    end
    reset = 1'b0; start = 1'b0; repeat_en = 1'b0;
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
